fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Y86-64 fetch stage: owns the F_predPC register, selects the fetch PC, splits the 10-byte
//  instruction window into icode/ifun/rA/rB/valC, computes valP and the predicted PC, and
//  drives the f_* bundle plus instr_valid/imem_error/halt into the decode pipeline register.
//  Sticky stop flag freezes fetch after a non-AOK instruction; 32-bit count of accepted fetches.
// PARAMETERS
//  RESET_PC   64'h0   F_predPC value on reset
//  IMEM_SIZE  4096    instruction memory size in bytes; fetch past it raises imem_error
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  F_stall     in   1   hold F_predPC, stop flag and fetch_count
//  M_icode     in   4   icode in memory stage (misprediction detect)
//  M_Cnd       in   1   branch outcome in memory stage
//  M_valA      in   64  fall-through PC of mispredicted jXX
//  W_icode     in   4   icode in writeback stage (ret detect)
//  W_valM      in   64  return address popped by ret
//  imem_addr   out  64  = f_pc
//  imem_rdata  in   80  bytes f_pc..f_pc+9, byte 0 in [7:0], combinational read
//  f_icode/f_ifun/f_rA/f_rB  out 4 each   decoded fields
//  f_valC      out  64  constant word; f_valP out 64 = f_pc + length
//  f_stat      out  4   AOK 0001, HLT 0010, ADR 0100, INS 1000
//  instr_valid out  1   1 = illegal icode/ifun (decode register maps to INS)
//  imem_error  out  1   f_pc + length > IMEM_SIZE
//  halt        out  1   f_icode == HALT
//  stopped     out  1   sticky stop flag
//  fetch_count out  32  accepted fetches, wraps at 2^32
// BEHAVIOUR
//  - Reset (async, rst_n low): F_predPC=RESET_PC, stopped=0, fetch_count=0. Others combinational.
//  - f_pc: M_icode==JXX && !M_Cnd -> M_valA; else W_icode==RET -> W_valM; else F_predPC.
//  - Lengths: HALT/NOP/RET 1; RRMOVQ(cmov)/OPQ/PUSHQ/POPQ 2; JXX/CALL 9; IRMOVQ/RMMOVQ/MRMOVQ 10.
//  - need_regids (2,3,4,5,6,A,B): rA=byte1[7:4], rB=byte1[3:0]; else rA=rB=4'hF.
//  - need_valC (3,4,5,7,8): valC = 8 LE bytes from offset 2 (regids) or 1; else 0.
//  - Valid: icode 0..B; ifun 0..3 for OPQ, 0..6 for JXX/RRMOVQ, 0 otherwise.
//  - imem_error: f_icode forced NOP(1), f_ifun 0, instr_valid 0, f_stat ADR.
//    Length from raw icode; illegal icode uses length 1 for the range check.
//  - f_stat priority: ADR > INS > HLT > AOK.
//  - predPC = valC for JXX/CALL, else valP.
//  - Clock edge, F_stall=1: all state holds.
//  - Clock edge, F_stall=0, redirect (either f_pc select term true): F_predPC<=predPC,
//    stopped<=(f_stat!=AOK), fetch_count+1. Redirect overrides stopped (wrong-path halt).
//  - Clock edge, F_stall=0, stopped=1, no redirect: state holds; outputs keep re-presenting
//    the stopping instruction.
//  - Clock edge, F_stall=0, stopped=0, no redirect: F_predPC<=predPC,
//    stopped<=(f_stat!=AOK), fetch_count+1.
//  - fetch_count wraps FFFF_FFFF -> 0. Reset mid-operation returns to reset values at once.
// STRUCTURE
//  - Shared package y86_pkg: icode constants (HALT..POPQ), stat codes AOK/HLT/ADR/INS,
//    RNONE=4'hF, JXX ifun range.
//  - One sub-module instr_split: combinational byte window -> icode/ifun/rA/rB/valC/length/valid.
//  - Top holds PC select, predPC logic, F register, stop flag and counter.
// TESTING
//  - Reset, imem bytes 30 F3 0A 00..00 (irmovq $10,%rbx) -> f_pc 0, rA F, rB 3, valC 10,
//    valP 0x0A, AOK; next edge F_predPC 0x0A, fetch_count 1.
//  - call at 0x20, target 0x100 -> predPC 0x100. Then M_icode=JXX, M_Cnd=0, M_valA=0x55
//    -> f_pc 0x55 same cycle.
//  - Halt (byte 00) fetched -> f_stat HLT, halt 1, stopped 1 after edge, F_predPC and count
//    frozen; then mispredict redirect -> stopped 0, fetch resumes at M_valA.
//  - Byte 0xC0 -> instr_valid 1, f_stat INS; OPq ifun 4 (byte 64) -> INS.
//  - IMEM_SIZE=16, f_pc 0x0A with irmovq -> imem_error 1, f_stat ADR, f_icode NOP.
//  - F_stall=1 for 3 cycles with nop stream -> F_predPC/fetch_count unchanged;
//    W_icode=RET with W_valM=0x40 -> f_pc 0x40.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the fetch stage and its byte-window decoder.
package y86_pkg;

  localparam logic [3:0] IcodeHalt   = 4'h0;
  localparam logic [3:0] IcodeNop    = 4'h1;
  localparam logic [3:0] IcodeRrmovq = 4'h2;
  localparam logic [3:0] IcodeIrmovq = 4'h3;
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeOpq    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  localparam logic [3:0] StatAok = 4'b0001;
  localparam logic [3:0] StatHlt = 4'b0010;
  localparam logic [3:0] StatAdr = 4'b0100;
  localparam logic [3:0] StatIns = 4'b1000;

  localparam logic [3:0] Rnone      = 4'hF;
  localparam logic [3:0] OpqIfunMax = 4'd3;
  localparam logic [3:0] JxxIfunMax = 4'd6;

  // Illegal icodes report length 1 so the address range check still has a size.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      IcodeRrmovq, IcodeOpq, IcodePushq, IcodePopq: len = 4'd2;
      IcodeJxx, IcodeCall:                          len = 4'd9;
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq:        len = 4'd10;
      default:                                      len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_split.sv
// Splits a 10-byte little-endian instruction window into Y86-64 fields, length and legality.
module instr_split
  import y86_pkg::*;
(
  input  logic [79:0] bytes,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [3:0]  length,
  output logic        legal
);

  logic need_regids;
  logic need_valc;

  assign icode  = bytes[7:4];
  assign ifun   = bytes[3:0];
  assign length = instr_len(bytes[7:4]);

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    legal       = 1'b1;
    ra          = Rnone;
    rb          = Rnone;
    valc        = '0;
    case (icode)
      IcodeHalt, IcodeNop, IcodeRet: legal = (ifun == 4'h0);
      IcodeRrmovq: begin
        need_regids = 1'b1;
        legal       = (ifun <= JxxIfunMax);
      end
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
        legal       = (ifun == 4'h0);
      end
      IcodeOpq: begin
        need_regids = 1'b1;
        legal       = (ifun <= OpqIfunMax);
      end
      IcodeJxx: begin
        need_valc = 1'b1;
        legal     = (ifun <= JxxIfunMax);
      end
      IcodeCall: begin
        need_valc = 1'b1;
        legal     = (ifun == 4'h0);
      end
      IcodePushq, IcodePopq: begin
        need_regids = 1'b1;
        legal       = (ifun == 4'h0);
      end
      default: legal = 1'b0;
    endcase

    if (need_regids) begin
      ra = bytes[15:12];
      rb = bytes[11:8];
    end
    // valC starts after the register byte when one is present.
    if (need_valc) begin
      valc = need_regids ? bytes[79:16] : bytes[71:8];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split, PC prediction, sticky stop and fetch counter.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IMEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_rdata,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic [3:0]  f_stat,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        halt,
  output logic        stopped,
  output logic [31:0] fetch_count
);

  logic [63:0] pred_pc_q, pred_pc_d;
  logic        stopped_q, stopped_d;
  logic [31:0] count_q, count_d;

  logic        mispredict;
  logic        ret_redirect;
  logic        redirect;
  logic [63:0] f_pc;
  logic [63:0] pred_pc;
  logic [64:0] end_addr;

  logic [3:0]  raw_icode;
  logic [3:0]  raw_ifun;
  logic [3:0]  raw_len;
  logic        raw_legal;

  assign mispredict   = (M_icode == IcodeJxx) && !M_Cnd;
  assign ret_redirect = (W_icode == IcodeRet);
  assign redirect     = mispredict || ret_redirect;

  always_comb begin
    if (mispredict) begin
      f_pc = M_valA;
    end else if (ret_redirect) begin
      f_pc = W_valM;
    end else begin
      f_pc = pred_pc_q;
    end
  end

  assign imem_addr = f_pc;

  instr_split u_split (
    .bytes  (imem_rdata),
    .icode  (raw_icode),
    .ifun   (raw_ifun),
    .ra     (f_rA),
    .rb     (f_rB),
    .valc   (f_valC),
    .length (raw_len),
    .legal  (raw_legal)
  );

  // One extra bit so a PC near 2^64 cannot wrap past the range check.
  assign end_addr   = {1'b0, f_pc} + 65'(raw_len);
  assign imem_error = (end_addr > 65'(IMEM_SIZE));
  assign f_valP     = f_pc + 64'(raw_len);

  assign f_icode     = imem_error ? IcodeNop : raw_icode;
  assign f_ifun      = imem_error ? 4'h0 : raw_ifun;
  assign instr_valid = !imem_error && !raw_legal;
  assign halt        = (f_icode == IcodeHalt);

  always_comb begin
    if (imem_error) begin
      f_stat = StatAdr;
    end else if (!raw_legal) begin
      f_stat = StatIns;
    end else if (raw_icode == IcodeHalt) begin
      f_stat = StatHlt;
    end else begin
      f_stat = StatAok;
    end
  end

  assign pred_pc = ((f_icode == IcodeJxx) || (f_icode == IcodeCall)) ? f_valC : f_valP;

  // A stopping fetch parks F_predPC on itself so the same instruction keeps being presented.
  always_comb begin
    pred_pc_d = pred_pc_q;
    stopped_d = stopped_q;
    count_d   = count_q;
    if (!F_stall && (redirect || !stopped_q)) begin
      stopped_d = (f_stat != StatAok);
      pred_pc_d = (f_stat != StatAok) ? f_pc : pred_pc;
      count_d   = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
      stopped_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pred_pc_q <= pred_pc_d;
      stopped_q <= stopped_d;
      count_q   <= count_d;
    end
  end

  assign stopped     = stopped_q;
  assign fetch_count = count_q;

endmodule
